// File: rtl/window_scanner.sv
// -----------------------------------------------------------------------------
// window_scanner
//
// Loads a square SRCH x SRCH byte region from a word-wide memory port into
// local storage, then presents every WIN x WIN window of that region, stepping
// STRIDE bytes along a row and then STRIDE rows down, one window per accepted
// handshake.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   en / ack            start request (seen only in IDLE) / one-cycle acknowledge
//   rd_req              high while the region is being fetched
//   rd_row, rd_col      word address being fetched (row, word column)
//   rd_data, rd_valid   fetched word (byte 0 in the MSB) and its qualifier
//   window_data         WIN*WIN bytes, row-major, byte (0,0) in the LSB
//   window_valid        window_data / win_row / win_col are meaningful
//   window_accept       consumer takes the current window
//   win_row, win_col    top-left byte coordinate of the current window
//   done                pulse when the last window is accepted
//   busy                high whenever not IDLE
// -----------------------------------------------------------------------------
module window_scanner #(
    parameter int SRCH      = 80,
    parameter int WIN       = 16,
    parameter int BUS_BYTES = 4,
    parameter int STRIDE    = 1,
    localparam int CW       = $clog2(SRCH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic                     ack,
    output logic                     rd_req,
    output logic [CW-1:0]            rd_row,
    output logic [CW-1:0]            rd_col,
    input  logic [8*BUS_BYTES-1:0]   rd_data,
    input  logic                     rd_valid,
    output logic [WIN*WIN*8-1:0]     window_data,
    output logic                     window_valid,
    input  logic                     window_accept,
    output logic [CW-1:0]            win_row,
    output logic [CW-1:0]            win_col,
    output logic                     done,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SCAN
    } state_t;

    localparam logic [CW-1:0] LAST_ROW = CW'(SRCH - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(SRCH / BUS_BYTES - 1);
    localparam logic [CW-1:0] LAST_W   = CW'(SRCH - WIN);
    localparam logic [CW-1:0] STEP     = CW'(STRIDE);

    state_t        state_q, state_d;
    logic [CW-1:0] rd_row_q, rd_row_d;
    logic [CW-1:0] rd_col_q, rd_col_d;
    logic [CW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          wr_en;

    logic [7:0]    region_q [SRCH][SRCH];

    // Next-state, address stepping and pulse outputs.
    always_comb begin
        // NOTE: every output of this block is given a default first so that no
        // path through the case statement leaves a value unassigned (no latch).
        state_d   = state_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        wr_en     = 1'b0;
        ack       = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    ack      = 1'b1;
                    state_d  = S_FILL;
                    rd_row_d = '0;
                    rd_col_d = '0;
                end
            end

            S_FILL: begin
                if (rd_valid) begin
                    wr_en = 1'b1;
                    if (rd_col_q == LAST_COL) begin
                        rd_col_d = '0;
                        if (rd_row_q == LAST_ROW) begin
                            // Last word stored: park the read address and
                            // start scanning from the top-left window.
                            rd_row_d  = '0;
                            win_row_d = '0;
                            win_col_d = '0;
                            state_d   = S_SCAN;
                        end else begin
                            rd_row_d = rd_row_q + 1'b1;
                        end
                    end else begin
                        rd_col_d = rd_col_q + 1'b1;
                    end
                end
            end

            S_SCAN: begin
                if (window_accept) begin
                    if (win_col_q == LAST_W) begin
                        win_col_d = '0;
                        if (win_row_q == LAST_W) begin
                            done      = 1'b1;
                            win_row_d = '0;
                            state_d   = S_IDLE;
                        end else begin
                            win_row_d = win_row_q + STEP;
                        end
                    end else begin
                        win_col_d = win_col_q + STEP;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the values that existed before this clock edge.
            state_q   <= state_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    // NOTE: the region array has no reset; its contents only matter after a
    // complete FILL, and leaving it out of reset keeps it a plain memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BUS_BYTES; k++) begin
                region_q[rd_row_q][CW'(int'(rd_col_q) * BUS_BYTES + k)]
                    <= rd_data[8*(BUS_BYTES-k)-1 -: 8];
            end
        end
    end

    // Window gather: byte (i,j) of the window sits at bit offset (i*WIN+j)*8.
    always_comb begin
        window_data = '0;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                window_data[(i*WIN+j)*8 +: 8] =
                    region_q[CW'(int'(win_row_q) + i)][CW'(int'(win_col_q) + j)];
            end
        end
    end

    assign rd_req       = (state_q == S_FILL);
    assign busy         = (state_q != S_IDLE);
    assign window_valid = (state_q == S_SCAN);
    assign rd_row       = rd_row_q;
    assign rd_col       = rd_col_q;
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;

endmodule
